// File: rtl/led_sopc_nios2_qsys_ocimem_pkg.sv
// Shared definitions for the JTAG debug-memory access controller.
// The package holds the controller FSM state enum, the bit positions of the
// fields taken from the JTAG data word (jdo), and the default word-address
// width of the debug RAM.
package led_sopc_nios2_qsys_ocimem_pkg;

  localparam int unsigned RAM_ADDR_W_DEFAULT = 8;

  // jdo field positions
  localparam int unsigned JDO_RD_BIT    = 34;
  localparam int unsigned JDO_ADDR_HI   = 17;
  localparam int unsigned JDO_ADDR_LO   = 10;
  localparam int unsigned JDO_WDATA_HI  = 34;
  localparam int unsigned JDO_WDATA_LO  = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    J_RD      = 3'd1,
    J_RD_DATA = 3'd2,
    J_WR      = 3'd3,
    C_RD      = 3'd4,
    C_RD_DATA = 3'd5,
    C_DONE    = 3'd6
  } ocimem_state_e;

endpackage

// File: rtl/led_sopc_nios2_qsys_ocimem_ram.sv
// Single-port synchronous debug RAM, 2^ADDR_W x 32, byte-lane write enables,
// one-cycle registered read (old data on read-during-write). No reset; the
// contents power up undefined.
// Ports:
//   clk   - clock
//   addr  - word address
//   we    - write enable (qualified per lane by be)
//   be    - byte enables, be[i] covers wdata[8*i+7:8*i]
//   wdata - write data
//   q     - read data, valid the cycle after addr is presented
module led_sopc_nios2_qsys_ocimem_ram
  import led_sopc_nios2_qsys_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // One 8-bit-wide array per byte lane keeps every lane a plain
  // single-writer RAM that maps directly onto block memory.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[i]) begin
        mem[addr] <= wdata[8*i +: 8];
      end
      q[8*i +: 8] <= mem[addr];
    end
  end

endmodule

// File: rtl/led_sopc_nios2_qsys_jtag_ocimem.sv
// Debug-memory access controller. Services JTAG-initiated reads/writes of the
// on-chip debug RAM (commands arrive as one-cycle take_*_ocimem_* strobes with
// payload in jdo) and CPU accesses through an Avalon-MM slave with
// waitrequest, arbitrating both onto one single-port RAM.
// Ports:
//   clk, reset_n                   - system clock, async active-low reset
//   jdo                            - JTAG data word (rd flag, address, wdata)
//   take_action_ocimem_a           - load address, optionally request a read
//   take_no_action_ocimem_a        - increment address and read
//   take_action_ocimem_b           - write jdo data at current address
//   address, byteenable, chipselect,
//   read, write, debugaccess,
//   writedata, readdata, waitrequest - Avalon-MM CPU slave
//   MonDReg                        - JTAG data register (read result / wdata)
//   MonAReg                        - current JTAG word address
module led_sopc_nios2_qsys_jtag_ocimem
  import led_sopc_nios2_qsys_ocimem_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = RAM_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [RAM_ADDR_W-1:0] address,
  input  logic [3:0]            byteenable,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic                  debugaccess,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  output logic [31:0]           MonDReg,
  output logic [RAM_ADDR_W-1:0] MonAReg
);

  ocimem_state_e         state_q, state_d;
  logic                  jrd_pend_q, jrd_pend_d;
  logic                  jwr_pend_q, jwr_pend_d;
  logic [RAM_ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]           mon_d_q, mon_d_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  jrd_clr, jwr_clr;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_q;

  logic [RAM_ADDR_W-1:0] jdo_addr;
  logic [31:0]           jdo_wdata;
  logic                  jdo_rd;
  logic                  cpu_req;
  logic                  unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LO +: RAM_ADDR_W];
  assign jdo_wdata  = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
  assign jdo_rd     = jdo[JDO_RD_BIT];
  assign unused_jdo = ^{jdo[37:JDO_WDATA_HI+1], jdo[JDO_WDATA_LO-1:0]};
  assign cpu_req    = chipselect & (read | write);

  // Arbitration and RAM port steering
  always_comb begin
    state_d   = state_q;
    jrd_clr   = 1'b0;
    jwr_clr   = 1'b0;
    ram_addr  = address;
    ram_we    = 1'b0;
    ram_be    = '1;
    ram_wdata = writedata;

    case (state_q)
      IDLE: begin
        if (jwr_pend_q) begin
          state_d = J_WR;
        end else if (jrd_pend_q) begin
          state_d = J_RD;
        end else if (cpu_req) begin
          // read wins when read and write are both asserted
          if (read) begin
            state_d = C_RD;
          end else begin
            ram_we  = debugaccess;
            ram_be  = byteenable;
            state_d = C_DONE;
          end
        end
      end
      J_WR: begin
        ram_addr  = mon_a_q;
        ram_wdata = mon_d_q;
        ram_we    = 1'b1;
        jwr_clr   = 1'b1;
        state_d   = IDLE;
      end
      J_RD: begin
        ram_addr = mon_a_q;
        jrd_clr  = 1'b1;
        state_d  = J_RD_DATA;
      end
      J_RD_DATA: state_d = IDLE;
      C_RD:      state_d = C_RD_DATA;
      C_RD_DATA: state_d = C_DONE;
      C_DONE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // JTAG command registers. Strobes are applied after the FSM-driven
  // updates so a command arriving on a clearing edge is kept.
  always_comb begin
    jrd_pend_d = jrd_pend_q;
    jwr_pend_d = jwr_pend_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    rdata_d    = rdata_q;

    if (jrd_clr) jrd_pend_d = 1'b0;
    if (jwr_clr) jwr_pend_d = 1'b0;
    if (state_q == J_WR)      mon_a_d = mon_a_q + RAM_ADDR_W'(1);
    if (state_q == J_RD_DATA) mon_d_d = ram_q;
    if (state_q == C_RD_DATA) rdata_d = ram_q;

    if (take_action_ocimem_a) begin
      mon_a_d = jdo_addr;
      if (jdo_rd) jrd_pend_d = 1'b1;
    end
    if (take_no_action_ocimem_a) begin
      mon_a_d    = mon_a_q + RAM_ADDR_W'(1);
      jrd_pend_d = 1'b1;
    end
    if (take_action_ocimem_b) begin
      mon_d_d    = jdo_wdata;
      jwr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      jrd_pend_q <= 1'b0;
      jwr_pend_q <= 1'b0;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      jrd_pend_q <= jrd_pend_d;
      jwr_pend_q <= jwr_pend_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      rdata_q    <= rdata_d;
    end
  end

  led_sopc_nios2_qsys_ocimem_ram #(
    .ADDR_W (RAM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign readdata    = rdata_q;
  assign waitrequest = (state_q != C_DONE);
  assign MonDReg     = mon_d_q;
  assign MonAReg     = mon_a_q;

endmodule

// File: tb/tb_led_sopc_nios2_qsys_jtag_ocimem.sv
module tb_led_sopc_nios2_qsys_jtag_ocimem;

  typedef enum int {OP_A, OP_NA, OP_B, OP_CW, OP_CR, OP_CRW} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        dbg;
    logic        rd;
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        tk_a = 1'b0, tk_na = 1'b0, tk_b = 1'b0;
  logic [7:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, debugaccess = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;

  int n_vec = 0;
  int n_err = 0;

  // reference model: RAM contents and JTAG registers at transaction level
  logic [31:0] m_mem [256];
  logic [7:0]  m_a;
  logic [31:0] m_d;

  always #5 clk = ~clk;

  led_sopc_nios2_qsys_jtag_ocimem #(
    .RAM_ADDR_W (8)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (tk_a),
    .take_no_action_ocimem_a (tk_na),
    .take_action_ocimem_b    (tk_b),
    .address                 (address),
    .byteenable              (byteenable),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .debugaccess             (debugaccess),
    .writedata               (writedata),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Avalon master: present request at a negedge, hold until waitrequest=0,
  // drop after that cycle. cyc counts cycles the request was presented.
  task automatic cpu_access(input op_e op, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be_v, input logic dbg,
                            output logic [31:0] rdat, output int cyc);
    address     = a;
    byteenable  = be_v;
    writedata   = d;
    debugaccess = dbg;
    chipselect  = 1'b1;
    read        = (op != OP_CW);
    write       = (op != OP_CR);
    cyc = 1;
    while (waitrequest !== 1'b0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (waitrequest !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL cpu_wait_timeout: got waitrequest=%b after %0d cycles required 0", waitrequest, cyc);
    end
    rdat = readdata;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    chk("wait_low_one_cycle", 32'(waitrequest), 32'd1);
  endtask

  task automatic strobe_a(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[17:10] = a;
    jdo[34] = rd;
    tk_a = 1'b1;
    @(negedge clk);
    tk_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = {3'b000, d, 3'b000};
    tk_b = 1'b1;
    @(negedge clk);
    tk_b = 1'b0;
  endtask

  task automatic do_op(input op_e op, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be_v, input logic dbg, input logic rd,
                       output logic [31:0] rdat, output int cyc, output logic [31:0] mexp);
    rdat = '0;
    cyc  = 0;
    mexp = m_mem[a];
    case (op)
      OP_A: begin
        strobe_a(a, rd);
        repeat (4) @(negedge clk);
        m_a = a;
        if (rd) m_d = m_mem[m_a];
      end
      OP_NA: begin
        tk_na = 1'b1;
        @(negedge clk);
        tk_na = 1'b0;
        repeat (4) @(negedge clk);
        m_a = m_a + 8'd1;
        m_d = m_mem[m_a];
      end
      OP_B: begin
        strobe_b(d);
        repeat (3) @(negedge clk);
        m_d = d;
        m_mem[m_a] = d;
        m_a = m_a + 8'd1;
      end
      default: begin
        cpu_access(op, a, d, be_v, dbg, rdat, cyc);
        if (op == OP_CW && dbg) begin
          for (int i = 0; i < 4; i++)
            if (be_v[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        end
      end
    endcase
  endtask

  vec_t        tv [18];
  logic [31:0] rdat, mexp;
  int          cyc;
  op_e         rop;

  initial begin
    tv[0]  = '{OP_CW,  8'h00, 32'hA5A50001, 4'hF, 1'b1, 1'b0, 8'h00, 32'h00000000, 32'h0};
    tv[1]  = '{OP_A,   8'h10, 32'h0,        4'h0, 1'b0, 1'b0, 8'h10, 32'h00000000, 32'h0};
    tv[2]  = '{OP_B,   8'h00, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 8'h11, 32'hDEADBEEF, 32'h0};
    tv[3]  = '{OP_A,   8'h20, 32'h0,        4'h0, 1'b0, 1'b1, 8'h20, 32'h00000000, 32'h0};
    tv[4]  = '{OP_A,   8'h10, 32'h0,        4'h0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    tv[5]  = '{OP_NA,  8'h00, 32'h0,        4'h0, 1'b0, 1'b0, 8'h11, 32'h00000000, 32'h0};
    tv[6]  = '{OP_NA,  8'h00, 32'h0,        4'h0, 1'b0, 1'b0, 8'h12, 32'h00000000, 32'h0};
    tv[7]  = '{OP_A,   8'hFF, 32'h0,        4'h0, 1'b0, 1'b0, 8'hFF, 32'h00000000, 32'h0};
    tv[8]  = '{OP_NA,  8'h00, 32'h0,        4'h0, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'h0};
    tv[9]  = '{OP_CR,  8'h10, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'hDEADBEEF};
    tv[10] = '{OP_CW,  8'h05, 32'h12345678, 4'h3, 1'b1, 1'b0, 8'h00, 32'hA5A50001, 32'h0};
    tv[11] = '{OP_CR,  8'h05, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'h00005678};
    tv[12] = '{OP_CW,  8'h05, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'h0};
    tv[13] = '{OP_CR,  8'h05, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'h00005678};
    tv[14] = '{OP_CRW, 8'h05, 32'h00000000, 4'hF, 1'b1, 1'b0, 8'h00, 32'hA5A50001, 32'h00005678};
    tv[15] = '{OP_CR,  8'h05, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'h00005678};
    tv[16] = '{OP_CW,  8'h05, 32'hAB000000, 4'h8, 1'b1, 1'b0, 8'h00, 32'hA5A50001, 32'h0};
    tv[17] = '{OP_CR,  8'h05, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 32'hA5A50001, 32'hAB005678};

    // reset
    repeat (3) @(negedge clk);
    chk("rst_wait",  32'(waitrequest), 32'd1);
    chk("rst_rdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mona",  32'(MonAReg), 32'h0);
    chk("rst_mond",  MonDReg, 32'h0);
    chk("idle_wait", 32'(waitrequest), 32'd1);

    // clear RAM through auto-incrementing JTAG writes
    m_a = '0;
    m_d = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    do_op(OP_A, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, rdat, cyc, mexp);
    for (int i = 0; i < 256; i++) do_op(OP_B, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, rdat, cyc, mexp);
    chk("clr_mona", 32'(MonAReg), 32'h0);
    chk("clr_mond", MonDReg, 32'h0);

    // directed table
    for (int v = 0; v < 18; v++) begin
      do_op(tv[v].op, tv[v].addr, tv[v].data, tv[v].be, tv[v].dbg, tv[v].rd, rdat, cyc, mexp);
      chk($sformatf("tv%0d_mona", v), 32'(MonAReg), 32'(tv[v].exp_a));
      chk($sformatf("tv%0d_mond", v), MonDReg, tv[v].exp_d);
      if (tv[v].op == OP_CR || tv[v].op == OP_CRW) begin
        chk($sformatf("tv%0d_rdata", v), rdat, tv[v].exp_rdata);
        chk($sformatf("tv%0d_rd_cycles", v), 32'(cyc), 32'd4);
      end else if (tv[v].op == OP_CW) begin
        chk($sformatf("tv%0d_wr_cycles", v), 32'(cyc), 32'd2);
      end
    end

    // randomized transactions against the model
    for (int k = 0; k < 300; k++) begin
      logic [7:0]  ra;
      logic [31:0] rd32;
      logic [3:0]  rbe;
      ra   = 8'($urandom);
      rd32 = $urandom;
      rbe  = 4'($urandom);
      rop  = op_e'($urandom_range(0, 5));
      do_op(rop, ra, rd32, rbe, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdat, cyc, mexp);
      chk("rnd_mona", 32'(MonAReg), 32'(m_a));
      chk("rnd_mond", MonDReg, m_d);
      if (rop == OP_CR || rop == OP_CRW) begin
        chk("rnd_rdata", rdat, mexp);
        chk("rnd_rd_cycles", 32'(cyc), 32'd4);
      end else if (rop == OP_CW) begin
        chk("rnd_wr_cycles", 32'(cyc), 32'd2);
      end
    end

    // JTAG read latency: MonDReg updates after the third edge past the strobe
    do_op(OP_B, 8'h00, 32'h0BADF00D, 4'h0, 1'b0, 1'b0, rdat, cyc, mexp);
    do_op(OP_CW, 8'h30, 32'h5EED1234, 4'hF, 1'b1, 1'b0, rdat, cyc, mexp);
    strobe_a(8'h30, 1'b1);
    chk("jrd_mona_e0", 32'(MonAReg), 32'h30);
    @(negedge clk);
    @(negedge clk);
    chk("jrd_mond_e2", MonDReg, 32'h0BADF00D);
    @(negedge clk);
    chk("jrd_mond_e3", MonDReg, 32'h5EED1234);
    @(negedge clk);

    // JTAG write timing: RAM write and address increment at second edge
    strobe_b(32'h600DCAFE);
    chk("jwr_mond_e0", MonDReg, 32'h600DCAFE);
    chk("jwr_mona_e0", 32'(MonAReg), 32'h30);
    @(negedge clk);
    chk("jwr_mona_e1", 32'(MonAReg), 32'h30);
    @(negedge clk);
    chk("jwr_mona_e2", 32'(MonAReg), 32'h31);
    m_mem[8'h30] = 32'h600DCAFE;
    m_d = 32'h600DCAFE;
    m_a = 8'h31;
    do_op(OP_CR, 8'h30, 32'h0, 4'hF, 1'b0, 1'b0, rdat, cyc, mexp);
    chk("jwr_readback", rdat, 32'h600DCAFE);

    // contention: JTAG write queued ahead of a CPU read of the same word
    do_op(OP_A, 8'h40, 32'h0, 4'h0, 1'b0, 1'b0, rdat, cyc, mexp);
    strobe_b(32'hCAFEF00D);
    m_mem[8'h40] = 32'hCAFEF00D;
    m_d = 32'hCAFEF00D;
    m_a = 8'h41;
    do_op(OP_CR, 8'h40, 32'h0, 4'hF, 1'b0, 1'b0, rdat, cyc, mexp);
    chk("cont_rdata", rdat, 32'hCAFEF00D);
    chk("cont_cycles", 32'(cyc), 32'd6);
    chk("cont_mona", 32'(MonAReg), 32'h41);

    // strobe arriving on the edge a J_RD clears its flag is still serviced
    do_op(OP_CW, 8'h41, 32'h11111111, 4'hF, 1'b1, 1'b0, rdat, cyc, mexp);
    do_op(OP_CW, 8'h42, 32'h22222222, 4'hF, 1'b1, 1'b0, rdat, cyc, mexp);
    do_op(OP_A, 8'h40, 32'h0, 4'h0, 1'b0, 1'b0, rdat, cyc, mexp);
    tk_na = 1'b1;
    @(negedge clk);
    tk_na = 1'b0;
    @(negedge clk);
    tk_na = 1'b1;
    @(negedge clk);
    tk_na = 1'b0;
    repeat (6) @(negedge clk);
    chk("setwin_mona", 32'(MonAReg), 32'h42);
    chk("setwin_mond", MonDReg, 32'h22222222);

    // reset during C_RD_DATA
    address    = 8'h42;
    byteenable = 4'hF;
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n    = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    #1;
    chk("rstmid_wait",  32'(waitrequest), 32'd1);
    chk("rstmid_rdata", readdata, 32'h0);
    chk("rstmid_mona",  32'(MonAReg), 32'h0);
    chk("rstmid_mond",  MonDReg, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_a = '0;
    m_d = '0;
    do_op(OP_CR, 8'h42, 32'h0, 4'hF, 1'b0, 1'b0, rdat, cyc, mexp);
    chk("rstmid_next_rdata", rdat, 32'h22222222);
    chk("rstmid_next_cycles", 32'(cyc), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_sopc_nios2_qsys_jtag_ocimem.md
# led_sopc_nios2_qsys_jtag_ocimem

Debug-memory access controller downstream of the JTAG debug module's system-clock half. It consumes `jdo` and the `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes, and performs JTAG-initiated reads and writes of the 256×32 on-chip debug RAM. Read results return in `MonDReg`, which feeds back to the JTAG TCK side for shift-out. The block also serves CPU accesses to the same RAM through an Avalon-MM slave with `waitrequest`, arbitrating both masters onto one single-port RAM.

## Interface
- `RAM_ADDR_W`, 8, word-address width of the debug RAM (depth 2^RAM_ADDR_W).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `jdo` in 38: JTAG data word. Fields used: [34] read-request flag, [17:10] word address, [34:3] write data.
- `take_action_ocimem_a` in 1: one-cycle strobe; load address, optionally request a read.
- `take_no_action_ocimem_a` in 1: one-cycle strobe; auto-increment address and read.
- `take_action_ocimem_b` in 1: one-cycle strobe; write `jdo[34:3]` at the current address.
- `address` in RAM_ADDR_W: CPU word address.
- `byteenable` in 4: CPU byte lanes.
- `chipselect`, `read`, `write` in 1 each: CPU access qualifiers.
- `debugaccess` in 1: CPU writes take effect only when this is 1.
- `writedata` in 32: CPU write data.
- `readdata` out 32: CPU read data.
- `waitrequest` out 1: Avalon stall.
- `MonDReg` out 32: JTAG data register (read result / last write data).
- `MonAReg` out RAM_ADDR_W: current JTAG word address.

## Operation
- FSM states: IDLE, J_RD, J_RD_DATA, J_WR, C_RD, C_RD_DATA, C_DONE.
- The RAM is synchronous-read with 1-cycle latency. JTAG writes use all byte enables.
- `take_action_ocimem_a`:
  - `MonAReg <= jdo[17:10]`.
  - If `jdo[34]`=1, set `jrd_pend`.
- `take_no_action_ocimem_a`:
  - `MonAReg <= MonAReg+1`, wrapping from 2^RAM_ADDR_W−1 to 0.
  - Set `jrd_pend`.
- `take_action_ocimem_b`:
  - `MonDReg <= jdo[34:3]`.
  - Set `jwr_pend`.
- Strobes are latched in every state; servicing waits for IDLE.
- IDLE priority: `jwr_pend` > `jrd_pend` > CPU request (`chipselect & (read|write)`).
- J_WR:
  - Write `MonDReg` to `MonAReg`, clear `jwr_pend`.
  - `MonAReg` increments (wrap) on the same edge.
  - Go to IDLE.
- J_RD: issue the address, clear `jrd_pend`. Then J_RD_DATA: `MonDReg <= ram_q`, go to IDLE.
- CPU write (IDLE with write):
  - Write with `byteenable` only if `debugaccess`=1; otherwise silently dropped.
  - Go to C_DONE.
- CPU read: IDLE → C_RD (address issued) → C_RD_DATA (`readdata <= ram_q`) → C_DONE.
- C_DONE: `waitrequest`=0 for exactly one cycle, then IDLE.
- If `read` and `write` are both asserted, treat the access as a read.
- If a strobe arrives on the same edge that a J_* state clears its pending flag, the set wins and the new command is serviced next.
- A second identical strobe while its flag is already pending is merged. Address effects of a/no_action still apply immediately.

## Timing
- Reset values:
  - `MonAReg`=0, `MonDReg`=0, `readdata`=0, `waitrequest`=1.
  - FSM=IDLE, `jrd_pend`=`jwr_pend`=0.
  - RAM contents are not reset.
- Reset asserted mid-operation aborts the access and clears pending flags. A partially issued RAM write may or may not land.
- `waitrequest`=1 whenever not in C_DONE, including idle with no request.
- JTAG read from idle: strobe at edge 0, J_RD at edge 1, `MonDReg` valid after edge 3.
- JTAG write from idle: RAM written and `MonAReg` incremented at edge 2.
- CPU read from idle: request seen at edge 0, `waitrequest`=0 and `readdata` valid in the cycle after edge 3 (4-cycle access).
- CPU write from idle: `waitrequest`=0 in the cycle after edge 1 (2-cycle access).
- A CPU request waiting behind JTAG adds 2 cycles per queued JTAG command.

## Structure
- Shared package `led_sopc_nios2_qsys_ocimem_pkg` holds:
  - FSM state enum.
  - jdo field position constants (`JDO_RD_BIT`=34, `JDO_ADDR_HI/LO`=17/10, `JDO_WDATA_HI/LO`=34/3).
  - Default `RAM_ADDR_W`.
- Sub-module `led_sopc_nios2_qsys_ocimem_ram`: single-port synchronous RAM with byte enables and 1-cycle read latency, inferable by Quartus as M9K.

## Test plan
- Reset, then JTAG write: `take_action_ocimem_a` with `jdo[17:10]`=0x10, `jdo[34]`=0; then `take_action_ocimem_b` with `jdo[34:3]`=0xDEADBEEF → RAM[0x10]=0xDEADBEEF, `MonAReg`=0x11.
- JTAG read: `take_action_ocimem_a` with addr 0x10, rd=1 → `MonDReg`=0xDEADBEEF after 3 clocks. `take_no_action_ocimem_a` ×2 → `MonAReg`=0x12.
- Address wrap: set addr 0xFF, then `take_no_action_ocimem_a` → `MonAReg`=0x00, and `MonDReg` receives RAM[0].
- CPU access:
  - Write 0x12345678 to addr 5 with `byteenable`=0011, `debugaccess`=1 → read back 0x00005678 (RAM cleared first), with `waitrequest` low for exactly 1 cycle per access.
  - Same write with `debugaccess`=0 → no change.
- Contention: CPU read pending while `take_action_ocimem_b` fires → JTAG write completes first, CPU `waitrequest` stays high 2 extra cycles, `readdata` reflects the new data.
- Reset asserted during C_RD_DATA → `waitrequest`=1, `readdata`=0, FSM IDLE. Next CPU read completes normally.
